// File: rtl/usb_ram_arb.sv
// rtl/usb_ram_arb.sv - two-writer arbiter for the USB packet RAM write port
//
// Arbitrates the single write port of a dual-port RAM between the receive-path
// writer (rx) and the RAM-maintenance writer (rm). The owner holds the port for
// a burst. After MAX_BURST owned cycles it is pre-empted if the other port is
// waiting. Every handover goes through a one-cycle GAP bubble.
//
// Optional feature macro: USB_RAM_ARB_RR_EN
//   defined   : round-robin on simultaneous requests (rx wins first after reset)
//   undefined : fixed priority, rx always wins simultaneous requests
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   rx_req / rx_gnt            receive-path ownership request / grant
//   rx_txa, rx_txd, rx_txen    receive-path write address, data, strobe
//   rm_req / rm_gnt            maintenance ownership request / grant
//   rm_txa, rm_txd, rm_txen    maintenance write address, data, strobe
//   ram_txa, ram_txd, ram_txen arbitrated RAM write port (one cycle latency)
//   owner                      00 none, 01 rx, 10 rm
//   drop_err                   sticky: a write strobe was discarded
module usb_ram_arb #(
   parameter int AW        = 12,
   parameter int DW        = 8,
   parameter int MAX_BURST = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_req,
   output logic          rx_gnt,
   input  logic [AW-1:0] rx_txa,
   input  logic [DW-1:0] rx_txd,
   input  logic          rx_txen,
   input  logic          rm_req,
   output logic          rm_gnt,
   input  logic [AW-1:0] rm_txa,
   input  logic [DW-1:0] rm_txd,
   input  logic          rm_txen,
   output logic [AW-1:0] ram_txa,
   output logic [DW-1:0] ram_txd,
   output logic          ram_txen,
   output logic [1:0]    owner,
   output logic          drop_err
);

   localparam int            CW      = $clog2(MAX_BURST);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {IDLE, OWN_RX, OWN_RM, GAP} state_t;

   state_t        state;
   state_t        next;
   logic [CW-1:0] cnt;
   logic          cnt_max;
   logic          pick_rx;
   // Set while in GAP when the previous owner was pre-empted: the waiting
   // port must get the RAM next, even if the pre-empted one still requests.
   logic          hand_rx;
   logic          hand_rm;

   assign cnt_max = (cnt == CNT_MAX);

`ifdef USB_RAM_ARB_RR_EN
   logic last_rm;

   // On a tie grant the port that did not own last.
   assign pick_rx = rx_req & (~rm_req | last_rm);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_rm <= 1'b1;
      end else if ((next == OWN_RX || next == OWN_RM) && next != state) begin
         last_rm <= (next == OWN_RM);
      end
   end
`else
   assign pick_rx = rx_req;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next = state;
      case (state)
         IDLE, GAP: begin
            if (hand_rm && rm_req) begin
               next = OWN_RM;
            end else if (hand_rx && rx_req) begin
               next = OWN_RX;
            end else if (pick_rx) begin
               next = OWN_RX;
            end else if (rm_req) begin
               next = OWN_RM;
            end else begin
               next = IDLE;
            end
         end
         OWN_RX: begin
            if (!rx_req || (cnt_max && rm_req)) begin
               next = GAP;
            end
         end
         OWN_RM: begin
            if (!rm_req || (cnt_max && rx_req)) begin
               next = GAP;
            end
         end
         default: next = IDLE;
      endcase
   end

   // Burst counter, handover flags and registered state decodes.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         hand_rx <= 1'b0;
         hand_rm <= 1'b0;
         rx_gnt  <= 1'b0;
         rm_gnt  <= 1'b0;
         owner   <= 2'b00;
      end else begin
         if ((next == OWN_RX || next == OWN_RM) && next != state) begin
            cnt <= '0;
         end else if ((state == OWN_RX || state == OWN_RM) && !cnt_max) begin
            cnt <= cnt + 1'b1;
         end
         // Leaving OWN while still requesting can only be a pre-emption.
         hand_rm <= (state == OWN_RX) && (next == GAP) && rx_req;
         hand_rx <= (state == OWN_RM) && (next == GAP) && rm_req;
         rx_gnt  <= (next == OWN_RX);
         rm_gnt  <= (next == OWN_RM);
         owner   <= {next == OWN_RM, next == OWN_RX};
      end
   end

   // Write path: only the current owner's strobe reaches the RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_txa  <= '0;
         ram_txd  <= '0;
         ram_txen <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         ram_txen <= (rx_gnt & rx_txen) | (rm_gnt & rm_txen);
         if (rx_gnt && rx_txen) begin
            ram_txa <= rx_txa;
            ram_txd <= rx_txd;
         end else if (rm_gnt && rm_txen) begin
            ram_txa <= rm_txa;
            ram_txd <= rm_txd;
         end
         if ((rx_txen && !rx_gnt) || (rm_txen && !rm_gnt)) begin
            drop_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_usb_ram_arb.sv
// tb/tb_usb_ram_arb.sv - self-checking bench for usb_ram_arb (MAX_BURST=4)
module tb_usb_ram_arb;

   localparam int AW = 12;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_req, rx_gnt, rx_txen;
   logic [AW-1:0] rx_txa;
   logic [DW-1:0] rx_txd;
   logic          rm_req, rm_gnt, rm_txen;
   logic [AW-1:0] rm_txa;
   logic [DW-1:0] rm_txd;
   logic [AW-1:0] ram_txa;
   logic [DW-1:0] ram_txd;
   logic          ram_txen;
   logic [1:0]    owner;
   logic          drop_err;

   int checks = 0;
   int errors = 0;
   logic [AW+DW-1:0] sb[$];

   usb_ram_arb #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .rx_req(rx_req), .rx_gnt(rx_gnt), .rx_txa(rx_txa), .rx_txd(rx_txd), .rx_txen(rx_txen),
      .rm_req(rm_req), .rm_gnt(rm_gnt), .rm_txa(rm_txa), .rm_txd(rm_txd), .rm_txen(rm_txen),
      .ram_txa(ram_txa), .ram_txd(ram_txd), .ram_txen(ram_txen),
      .owner(owner), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   // Scoreboard: every RAM write must match the oldest accepted strobe.
   always @(negedge clk) begin
      if (ram_txen === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h required none", ram_txa, ram_txd);
         end else begin
            logic [AW+DW-1:0] e;
            e = sb.pop_front();
            if ({ram_txa, ram_txd} !== e) begin
               errors++;
               $display("FAIL write_data got=%h required=%h", {ram_txa, ram_txd}, e);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rx_strobe(input logic [AW-1:0] a, input logic [DW-1:0] d);
      rx_txen = 1'b1;
      rx_txa  = a;
      rx_txd  = d;
      sb.push_back({a, d});
   endtask

   task automatic idle_all;
      rx_req = 0; rm_req = 0; rx_txen = 0; rm_txen = 0;
      repeat (3) tick();
   endtask

   task automatic test_reset;
      rst = 1; rx_req = 0; rm_req = 0; rx_txen = 0; rm_txen = 0;
      rx_txa = '0; rx_txd = '0; rm_txa = '0; rm_txd = '0;
      repeat (2) tick();
      checks++;
      if ({rx_gnt, rm_gnt, ram_txen, drop_err, owner} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctl got=%b required=000000", {rx_gnt, rm_gnt, ram_txen, drop_err, owner});
      end
      checks++;
      if ({ram_txa, ram_txd} !== '0) begin
         errors++;
         $display("FAIL reset_data got=%h required=0", {ram_txa, ram_txd});
      end
      rst = 0;
      tick();
   endtask

   task automatic test_both_req;
      logic first_rx;
`ifdef USB_RAM_ARB_RR_EN
      first_rx = 1'b0;
`else
      first_rx = 1'b1;
`endif
      rx_req = 1; rm_req = 1;
      tick();
      checks++;
      if ({rx_gnt, rm_gnt, owner} !== 4'b1001) begin
         errors++;
         $display("FAIL tie_first got=%b required=1001", {rx_gnt, rm_gnt, owner});
      end
      rx_req = 0;
      tick();
      checks++;
      if ({rx_gnt, rm_gnt, owner} !== 4'b0000) begin
         errors++;
         $display("FAIL tie_gap got=%b required=0000", {rx_gnt, rm_gnt, owner});
      end
      rx_req = 1;
      tick();
      checks++;
      if ({rx_gnt, rm_gnt} !== {first_rx, ~first_rx}) begin
         errors++;
         $display("FAIL tie_regrant got=%b required=%b", {rx_gnt, rm_gnt}, {first_rx, ~first_rx});
      end
      if (first_rx) rx_req = 0; else rm_req = 0;
      tick();
      checks++;
      if ({rx_gnt, rm_gnt} !== 2'b00) begin
         errors++;
         $display("FAIL tie_gap2 got=%b required=00", {rx_gnt, rm_gnt});
      end
      tick();
      checks++;
      if ({rx_gnt, rm_gnt} !== {~first_rx, first_rx}) begin
         errors++;
         $display("FAIL tie_waiter got=%b required=%b", {rx_gnt, rm_gnt}, {~first_rx, first_rx});
      end
      idle_all();
   endtask

   task automatic test_rx_burst;
      rx_req = 1;
      tick();
      checks++;
      if ({rx_gnt, rm_gnt, owner} !== 4'b1001) begin
         errors++;
         $display("FAIL burst_gnt got=%b required=1001", {rx_gnt, rm_gnt, owner});
      end
      for (int i = 0; i < 3; i++) begin
         rx_strobe(12'h010 + 12'(i), 8'hc0 + 8'(i));
         tick();
      end
      rx_txen = 0;
      rx_req = 0;
      repeat (3) tick();
      checks++;
      if ({ram_txen, ram_txa, ram_txd} !== {1'b0, 12'h012, 8'hc2}) begin
         errors++;
         $display("FAIL burst_hold got=%h required=%h", {ram_txen, ram_txa, ram_txd}, {1'b0, 12'h012, 8'hc2});
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL burst_writes pending=%0d required=0", sb.size());
      end
      idle_all();
   endtask

   task automatic test_preempt;
      logic [11:0] exp_rx, exp_rm;
      exp_rx = 12'b110000001111;   // bit k-1 = rx_gnt after edge k
      exp_rm = 12'b000111100000;
      rx_req = 1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) rm_req = 1;
         rx_txen = 0;
         if (k <= 4) rx_strobe(12'h100 + 12'(k), 8'(k * 3));
         checks++;
         if ({rx_gnt, rm_gnt} !== {exp_rx[k-1], exp_rm[k-1]}) begin
            errors++;
            $display("FAIL preempt_k%0d got=%b required=%b", k, {rx_gnt, rm_gnt}, {exp_rx[k-1], exp_rm[k-1]});
         end
      end
      idle_all();
      checks++;
      if (sb.size() != 0 || drop_err !== 1'b0) begin
         errors++;
         $display("FAIL preempt_writes pending=%0d drop_err=%b required 0 0", sb.size(), drop_err);
      end
   endtask

   task automatic test_drop;
      rx_req = 1;
      tick();
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (rx_gnt !== 1'b1) begin
            errors++;
            $display("FAIL hold_k%0d rx_gnt=%b required=1", k, rx_gnt);
         end
      end
      rm_txen = 1; rm_txa = 12'h3ff; rm_txd = 8'haa;
      tick();
      rm_txen = 0;
      rm_req = 1;
      checks++;
      if ({drop_err, ram_txen} !== 2'b10) begin
         errors++;
         $display("FAIL drop_flag got=%b required=10", {drop_err, ram_txen});
      end
      tick();
      checks++;
      if ({rx_gnt, rm_gnt} !== 2'b00) begin
         errors++;
         $display("FAIL sat_preempt got=%b required=00", {rx_gnt, rm_gnt});
      end
      tick();
      checks++;
      if ({rx_gnt, rm_gnt} !== 2'b01) begin
         errors++;
         $display("FAIL sat_handover got=%b required=01", {rx_gnt, rm_gnt});
      end
      idle_all();
      checks++;
      if (drop_err !== 1'b1) begin
         errors++;
         $display("FAIL drop_sticky got=%b required=1", drop_err);
      end
   endtask

   task automatic test_reset_mid;
      rx_req = 1;
      tick();
      rx_strobe(12'h020, 8'h5a);
      tick();
      rst = 1; rx_req = 0;
      rx_txen = 1; rx_txa = 12'h021; rx_txd = 8'h77;
      tick();
      checks++;
      if ({rx_gnt, rm_gnt, ram_txen, owner, drop_err} !== 6'b0) begin
         errors++;
         $display("FAIL rst_mid_ctl got=%b required=000000", {rx_gnt, rm_gnt, ram_txen, owner, drop_err});
      end
      checks++;
      if ({ram_txa, ram_txd} !== '0) begin
         errors++;
         $display("FAIL rst_mid_data got=%h required=0", {ram_txa, ram_txd});
      end
      rst = 0; rx_txen = 0; rx_req = 1;
      tick();
      checks++;
      if ({rx_gnt, owner} !== 3'b101) begin
         errors++;
         $display("FAIL rst_mid_idle got=%b required=101", {rx_gnt, owner});
      end
      idle_all();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL rst_mid_writes pending=%0d required=0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_both_req();
      test_rx_burst();
      test_preempt();
      test_drop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb_ram_arb.md
USB_RAM_ARB -- requirements
Module: usb_ram_arb

Interface
REQ-001 Parameter AW, default 12, SHALL set the RAM address width.
REQ-002 Parameter DW, default 8, SHALL set the RAM data width.
REQ-003 Parameter MAX_BURST, default 64, SHALL set the owned cycles after which the arbiter pre-empts the owner if the other port is requesting; legal range 2..4096.
REQ-004 clk  in  1  single clock, the USB rx-side domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rx_req  in  1  receive-path writer requests RAM ownership.
REQ-007 rx_gnt  out  1  receive-path writer owns the RAM write port.
REQ-008 rx_txa / rx_txd / rx_txen  in  AW / DW / 1  receive-path write address, data and strobe.
REQ-009 rm_req  in  1  RAM-maintenance writer requests ownership.
REQ-010 rm_gnt  out  1  maintenance writer owns the RAM write port.
REQ-011 rm_txa / rm_txd / rm_txen  in  AW / DW / 1  maintenance write address, data and strobe.
REQ-012 ram_txa / ram_txd / ram_txen  out  AW / DW / 1  arbitrated write port to the dual-port RAM.
REQ-013 owner  out  2  current owner: 00 none, 01 rx, 10 rm; 11 never driven.
REQ-014 drop_err  out  1  sticky flag, set when any write strobe is discarded.

Function
REQ-015 The FSM SHALL have four states: IDLE, OWN_RX, OWN_RM and GAP.
REQ-016 IDLE or GAP with at least one req SHALL move to OWN_x of the winner on the next edge; with no req it SHALL move to IDLE.
REQ-017 rx_gnt and rm_gnt SHALL be registered and decoded from state, so a grant is asserted from the first cycle in OWN_x and is never asserted on both ports.
REQ-018 OWN_x with x_req low SHALL go to GAP; the grant SHALL drop in the same edge.
REQ-019 A burst counter SHALL clear on entry to OWN_x and increment each owned cycle, saturating at MAX_BURST-1.
REQ-020 When the counter equals MAX_BURST-1 and the other req is high, the FSM SHALL go to GAP.
REQ-021 When the counter equals MAX_BURST-1 and the other req is low, ownership SHALL continue and the counter SHALL hold.
REQ-022 A pre-empted requester SHALL keep req high; the arbiter SHALL re-grant it after the other port's burst.
REQ-023 GAP SHALL last exactly one cycle with both grants low, giving a one-cycle handover bubble.
REQ-024 On ram_*: an owner strobe (x_txen high with x_gnt high) SHALL appear on ram_txa, ram_txd and ram_txen one cycle later.
REQ-025 When no strobe is registered, ram_txen SHALL be 0 and ram_txa/ram_txd SHALL hold their last values.
REQ-026 A strobe from a non-owner, or any strobe in IDLE or GAP, SHALL be discarded and SHALL set drop_err until reset.
REQ-027 owner SHALL be registered and equal the state decode: OWN_RX gives 01, OWN_RM gives 10, otherwise 00.
REQ-028 When both ports request simultaneously in IDLE or GAP, the winner SHALL be chosen per REQ-033/034.

Reset
REQ-029 rst high at an edge SHALL put the FSM in IDLE and clear the burst counter.
REQ-030 rst high at an edge SHALL drive rx_gnt, rm_gnt, ram_txen, drop_err and owner to 0, and ram_txa and ram_txd to 0.
REQ-031 rst high at an edge SHALL set the last-owner register to rm.
REQ-032 Reset asserted mid-burst SHALL abort the burst with no further RAM write; a strobe registered on that edge SHALL be discarded.

Configuration
REQ-033 With USB_RAM_ARB_RR_EN defined, simultaneous requests SHALL grant the port that was not the last owner (round-robin); after reset, rx wins first.
REQ-034 With USB_RAM_ARB_RR_EN undefined, rx SHALL always win simultaneous requests (fixed priority), and the last-owner register SHALL be omitted.

Verification
REQ-035 Scenario: rx_req high alone, 3 strobes at addresses 0x010..0x012 -> rx_gnt high 1 cycle after req; ram_txen high for 3 cycles, each 1 cycle after its strobe, with matching data; owner=01.
REQ-036 Scenario: both req high from IDLE, RR_EN defined -> rx granted first; after rx_req drops, 1 GAP cycle, then rm_gnt high.
REQ-037 Scenario: both req high from IDLE, RR_EN undefined, rx re-requests during GAP -> rx regains ownership and rm waits.
REQ-038 Scenario: MAX_BURST=4, rx streaming, rm_req high -> rx_gnt high exactly 4 cycles, GAP, then rm_gnt high.
REQ-039 Scenario: rm_txen pulsed while rx owns -> no RAM write; drop_err=1 and stays 1 until rst.
REQ-040 Scenario: rst asserted during the 2nd cycle of an rx burst -> next cycle all grants, ram_txen and owner are 0 and the FSM is in IDLE.
